// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared state encoding and counter-width helper for the
//                alarm controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ENTRY    = 2'd2,
        ALARM    = 2'd3
    } state_t;

    // Width needed to hold the longer of the two timed intervals.
    function automatic int cw_f(input int entry_cyc, input int hold_cyc);
        int m;
        m = (entry_cyc > hold_cyc) ? entry_cyc : hold_cyc;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcount.sv
`default_nettype none
// ============================================================================
//  Module      : dcount
//  Description : Loadable down counter with enable and zero flag; holds at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcount #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl
//  Description : Four-state zone alarm controller with entry delay, timed
//                alarm hold, auto re-arm and first-trip zone memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int               ZONES      = 4,
    parameter int               ENTRY_CYC  = 8,
    parameter int               HOLD_CYC   = 16,
    parameter logic [ZONES-1:0] DELAY_MASK = 4'b0001,
    localparam int              CW         = cw_f(ENTRY_CYC, HOLD_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ZONES-1:0] D,
    input  logic             A,
    input  logic             X,
    output logic             L,
    output logic             armed,
    output logic             pending,
    output logic             arm_fail,
    output logic [ZONES-1:0] zmem,
    output logic [CW-1:0]    cnt
);

    localparam logic [CW-1:0] c_entry_ld = CW'(ENTRY_CYC - 1);
    localparam logic [CW-1:0] c_hold_ld  = CW'(HOLD_CYC - 1);

    state_t          r_state;
    logic            w_inst;
    logic            w_dly;
    logic            w_zero;
    logic            w_load;
    logic            w_en;
    logic [CW-1:0]   w_load_val;

    assign w_inst = |(D & ~DELAY_MASK);
    assign w_dly  = |(D &  DELAY_MASK);

    // Counter steering mirrors the state transitions below; disarm clears it.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_en       = 1'b0;
        unique case (r_state)
            ARMED: begin
                if (X) begin
                    w_load = 1'b1;
                end else if (w_inst) begin
                    w_load     = 1'b1;
                    w_load_val = c_hold_ld;
                end else if (w_dly) begin
                    w_load     = 1'b1;
                    w_load_val = c_entry_ld;
                end
            end
            ENTRY: begin
                if (X) begin
                    w_load = 1'b1;
                end else if (w_inst || w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_hold_ld;
                end else begin
                    w_en = 1'b1;
                end
            end
            ALARM: begin
                if (X) begin
                    w_load = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    dcount #(
        .W (CW)
    ) u_dcount (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .cnt      (cnt),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DISARMED;
            L        <= 1'b0;
            armed    <= 1'b0;
            pending  <= 1'b0;
            arm_fail <= 1'b0;
            zmem     <= '0;
        end else begin
            arm_fail <= 1'b0;
            if (r_state != DISARMED) begin
                zmem <= zmem | D;
            end
            unique case (r_state)
                DISARMED: begin
                    if (A) begin
                        if (D == '0) begin
                            r_state <= ARMED;
                            armed   <= 1'b1;
                            zmem    <= '0;
                        end else begin
                            arm_fail <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (X) begin
                        r_state <= DISARMED;
                        armed   <= 1'b0;
                    end else if (w_inst) begin
                        r_state <= ALARM;
                        L       <= 1'b1;
                    end else if (w_dly) begin
                        r_state <= ENTRY;
                        pending <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (X) begin
                        r_state <= DISARMED;
                        armed   <= 1'b0;
                        pending <= 1'b0;
                    end else if (w_inst || w_zero) begin
                        r_state <= ALARM;
                        pending <= 1'b0;
                        L       <= 1'b1;
                    end
                end
                ALARM: begin
                    if (X) begin
                        r_state <= DISARMED;
                        armed   <= 1'b0;
                        L       <= 1'b0;
                    end else if (w_zero) begin
                        r_state <= ARMED;
                        L       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= DISARMED;
                    armed   <= 1'b0;
                    pending <= 1'b0;
                    L       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ctrl
//  Description : Directed self-checking bench for alarm_ctrl (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D;
    logic       A;
    logic       X;
    logic       L;
    logic       armed;
    logic       pending;
    logic       arm_fail;
    logic [3:0] zmem;
    logic [4:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    alarm_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .A        (A),
        .X        (X),
        .L        (L),
        .armed    (armed),
        .pending  (pending),
        .arm_fail (arm_fail),
        .zmem     (zmem),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic ar, input logic p,
                           input logic af, input logic [3:0] z, input logic [4:0] c);
        chk({tag, ".L"},        32'(L),        32'(l));
        chk({tag, ".armed"},    32'(armed),    32'(ar));
        chk({tag, ".pending"},  32'(pending),  32'(p));
        chk({tag, ".arm_fail"}, 32'(arm_fail), 32'(af));
        chk({tag, ".zmem"},     32'(zmem),     32'(z));
        chk({tag, ".cnt"},      32'(cnt),      32'(c));
    endtask

    task automatic do_arm();
        A = 1'b1; step(1); A = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; D = '0; A = 1'b0; X = 1'b0;
        step(2);
        rst = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 4'h0, 5'd0);

        // Arm refused with a zone open
        A = 1'b1; D = 4'b0100; step(1);
        chk_all("arm_refused", 0, 0, 0, 1, 4'h0, 5'd0);
        A = 1'b0; D = '0; step(1);
        chk("arm_fail_pulse_end", 32'(arm_fail), 32'd0);
        chk("still_disarmed", 32'(armed), 32'd0);

        do_arm();
        chk_all("armed", 0, 1, 0, 0, 4'h0, 5'd0);
        A = 1'b1; step(1); A = 1'b0;
        chk_all("A_ignored_armed", 0, 1, 0, 0, 4'h0, 5'd0);

        // Delayed trip runs the full entry delay then the alarm hold
        D = 4'b0001; step(1); D = '0;
        chk_all("entry_start", 0, 1, 1, 0, 4'h1, 5'd7);
        step(7);
        chk_all("entry_end", 0, 1, 1, 0, 4'h1, 5'd0);
        step(1);
        chk_all("alarm_start", 1, 1, 0, 0, 4'h1, 5'd15);
        step(15);
        chk_all("alarm_last", 1, 1, 0, 0, 4'h1, 5'd0);
        step(1);
        chk_all("rearmed", 0, 1, 0, 0, 4'h1, 5'd0);

        // Disarm during entry delay
        D = 4'b0001; step(1); D = '0;
        chk("dis.pending", 32'(pending), 32'd1);
        step(2);
        X = 1'b1; step(1); X = 1'b0;
        chk_all("disarm_entry", 0, 0, 0, 0, 4'h1, 5'd0);
        step(10);
        chk_all("stay_disarmed", 0, 0, 0, 0, 4'h1, 5'd0);

        // Instant zone during entry delay, then disarm racing a trip
        do_arm();
        chk("rearm_clears_zmem", 32'(zmem), 32'd0);
        D = 4'b0001; step(1); D = '0;
        step(2);
        chk_all("entry_mid", 0, 1, 1, 0, 4'h1, 5'd5);
        D = 4'b0010; step(1); D = '0;
        chk_all("instant_in_entry", 1, 1, 0, 0, 4'h3, 5'd15);
        step(3);
        chk("alarm_cnt", 32'(cnt), 32'd12);
        X = 1'b1; D = 4'b0010; step(1); X = 1'b0; D = '0;
        chk_all("X_beats_trip_alarm", 0, 0, 0, 0, 4'h3, 5'd0);

        do_arm();
        X = 1'b1; D = 4'b0011; step(1); X = 1'b0; D = '0;
        chk_all("X_beats_trip_armed", 0, 0, 0, 0, 4'h3, 5'd0);

        // Zone held open retriggers after auto re-arm
        do_arm();
        D = 4'b0100; step(1);
        chk_all("instant_trip", 1, 1, 0, 0, 4'h4, 5'd15);
        step(16);
        chk_all("hold_done", 0, 1, 0, 0, 4'h4, 5'd0);
        step(1);
        chk_all("retrigger", 1, 1, 0, 0, 4'h4, 5'd15);
        D = '0;

        // Reset during alarm
        step(3);
        rst = 1'b1; step(1); rst = 1'b0;
        chk_all("rst_in_alarm", 0, 0, 0, 0, 4'h0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_ctrl.md
# alarm_ctrl

Parametrised, clocked successor to the single-output D/X/A → L combinational lamp logic. It monitors `ZONES` door/window sensor inputs and drives the alarm output `L` through a four-state controller with arm/disarm control, per-zone entry delay, timed alarm hold with automatic re-arm, and a first-trip zone memory. It sits between the debounced sensor inputs and the lamp/siren driver in the lab security design.

## Interface
Parameters:
- `ZONES`, 4: number of sensor zones (≥1).
- `ENTRY_CYC`, 8: entry-delay length in clock cycles (≥1).
- `HOLD_CYC`, 16: alarm hold length in clock cycles (≥1).
- `DELAY_MASK`, 4'b0001: bit i=1 means zone i is a delayed zone; 0 means instant.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `D`  in  ZONES  zone open (1 = open/tripped), level.
- `A`  in  1  arm request, sampled each cycle.
- `X`  in  1  disarm (valid code), sampled each cycle.
- `L`  out  1  alarm output, registered.
- `armed`  out  1  high in ARMED, ENTRY, ALARM.
- `pending`  out  1  high in ENTRY only.
- `arm_fail`  out  1  one-cycle pulse: arm refused.
- `zmem`  out  ZONES  latched zones that tripped since last arm.
- `cnt`  out  CW  active down-counter value; CW = $clog2(max(ENTRY_CYC,HOLD_CYC)+1).

## Operation
- States: DISARMED, ARMED, ENTRY, ALARM. All outputs registered; reset → DISARMED, L=0, armed=0, pending=0, arm_fail=0, zmem=0, cnt=0.
- Priority in every armed state: `X`=1 → DISARMED next cycle, cnt=0, L=0; overrides any simultaneous trip, expiry, or arm.
- DISARMED: `A`=1 and `D`==0 → ARMED, zmem cleared. `A`=1 with any `D` bit set → stay, arm_fail=1 for one cycle, zmem unchanged. `X` ignored.
- ARMED: any instant zone open (`D & ~DELAY_MASK`≠0) → ALARM, cnt=HOLD_CYC-1. Else any delayed zone open → ENTRY, cnt=ENTRY_CYC-1. Instant wins when both occur together.
- ENTRY: cnt decrements each cycle; instant zone open → ALARM immediately (cnt=HOLD_CYC-1); cnt==0 → ALARM. Further delayed-zone activity does not restart the count.
- ALARM: L=1; cnt decrements; cnt==0 → ARMED, L=0 (auto re-arm). A zone still open on re-entry to ARMED retriggers per ARMED rules on the next cycle.
- zmem: in ARMED/ENTRY/ALARM, zmem |= D each cycle; held through DISARMED until next accepted arm.
- `A` ignored outside DISARMED.

## Timing
- Input sampled at edge k → state/outputs updated at edge k+1.
- Instant trip at edge k → L=1 after edge k+1.
- Delayed trip at edge k → pending=1 after k+1; L=1 after edge k+ENTRY_CYC+1.
- L stays high exactly HOLD_CYC cycles, then armed=1, L=0.
- Disarm at edge k → L=0, armed=0 after k+1.
- `rst` mid-operation (any state) → reset values after that edge, zmem cleared.

## Structure
- Package `alarm_pkg`: state enum (DISARMED, ARMED, ENTRY, ALARM) and the CW width function.
- Sub-module `dcount`: loadable CW-bit down counter with load, enable, zero flag; one instance shared by ENTRY and ALARM.

## Test plan
- Reset, then `A`=1 with `D`=0 → armed=1 next cycle, L=0, zmem=0.
- Arm attempt with `D`=4'b0100 → arm_fail one-cycle pulse, armed=0.
- Armed, `D`=4'b0001 for one cycle, no `X` → pending=1, L=1 after 9 cycles (ENTRY_CYC=8), L held 16 cycles, then armed=1, L=0, zmem=4'b0001.
- Armed, `D`=4'b0001, `X`=1 three cycles later → DISARMED, L never asserted.
- In ENTRY, `D`=4'b0010 (instant) → L=1 next cycle; `X` and trip in same cycle → DISARMED, L=0.
- `rst` asserted during ALARM → L=0, zmem=0, DISARMED after that edge.
